seq_alu_exec: RTL and testbench

//  Multi-cycle execution unit consuming the 4-bit ALUinput code produced by the ALU

---
 rtl/seq_alu_exec.sv | 139 +++++++++++++
 tb/tb_seq_alu_exec.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_exec.sv
// Multi-cycle ALU execution unit: single-cycle logic/arith/compare,
// bit-serial shifter, start/busy/done handshake and zero flag.
module seq_alu_exec #(
  parameter int WIDTH = 64,
  parameter int SHW   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUinput,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   cnt;

  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] step;

  assign amt = in2[SHW-1:0];

  always_comb begin
    is_shift = 1'b0;
    case (ALUinput)
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default:                is_shift = 1'b0;
    endcase
  end

  // Shift codes only reach EXEC with a zero amount, so they pass a through.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
      OP_SLT:  result = {{(WIDTH-1){1'b0}},
                         $signed(a) < $signed(b)};
      OP_SLL,
      OP_SRL,
      OP_SRA:  result = a;
      default: result = '0;
    endcase
  end

  always_comb begin
    step = a;
    case (op)
      OP_SLL:  step = {a[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, a[WIDTH-1:1]};
      OP_SRA:  step = {a[WIDTH-1], a[WIDTH-1:1]};
      default: step = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      zero  <= 1'b1;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op   <= ALUinput;
            a    <= in1;
            b    <= in2;
            cnt  <= amt;
            busy <= 1'b1;
            if (is_shift && amt != '0)
              state <= SHIFT;
            else
              state <= EXEC;
          end
        end
        EXEC: begin
          out   <= result;
          zero  <= (result == '0);
          done  <= 1'b1;
          state <= DONE;
        end
        SHIFT: begin
          a   <= step;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            out   <= step;
            zero  <= (step == '0);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Directed self-checking bench for seq_alu_exec.
// Drives inputs 1 time unit after the rising edge and samples there.
module tb_seq_alu_exec;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic [63:0] in1;
  logic [63:0] in2;
  logic        busy;
  logic        done;
  logic [63:0] out;
  logic        zero;

  int tests;
  int fails;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  seq_alu_exec #(.WIDTH(64), .SHW(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ALUinput (alu_op),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op, then count edges until done (start cycle = 0).
  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input logic [63:0] exp,
                        input logic exp_z,
                        input int lat);
    int n;
    start  = 1'b1;
    alu_op = op;
    in1    = a;
    in2    = b;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, " lat"}, 64'(n), 64'(lat));
    check({tag, " out"}, out, exp);
    check({tag, " zero"}, 64'(zero), 64'(exp_z));
    check({tag, " busy"}, 64'(busy), 64'd1);
    tick();
    check({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    start  = 1'b0;
    alu_op = 4'b0;
    in1    = '0;
    in2    = '0;
    tick();
    tick();
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst out", out, 64'd0);
    check("rst zero", 64'(zero), 64'd1);
    reset = 1'b0;
    repeat (3) tick();
    check("quiet", {out[61:0], busy, done}, 64'd0);
    check("quiet zero", 64'(zero), 64'd1);

    run_op("add", 4'b0010, 64'h7, 64'h9, 64'h10, 1'b0, 2);
    run_op("sub0", 4'b0110, 64'h5, 64'h5, 64'h0, 1'b1, 2);
    run_op("subw", 4'b0110, 64'h0, 64'h1, ONES, 1'b0, 2);

    run_op("slt", 4'b1000, ONES, 64'h1, 64'h1, 1'b0, 2);
    run_op("sltu", 4'b0111, ONES, 64'h1, 64'h0, 1'b1, 2);
    run_op("and", 4'b0000, 64'hF0F0, 64'h0FF0,
           64'h00F0, 1'b0, 2);
    run_op("or", 4'b0001, 64'hF0F0, 64'h0FF0,
           64'hFFF0, 1'b0, 2);
    run_op("xor", 4'b0011, 64'hF0F0, 64'h0FF0,
           64'hFF00, 1'b0, 2);
    run_op("bad", 4'b1111, 64'h1234, 64'h1,
           64'h0, 1'b1, 2);

    run_op("sra63", 4'b1001, MSB, 64'd63, ONES, 1'b0, 64);
    run_op("srl63", 4'b0101, MSB, 64'd63, 64'h1, 1'b0, 64);
    run_op("sll0", 4'b0100, 64'h1, 64'd0, 64'h1, 1'b0, 2);
    run_op("sll64", 4'b0100, 64'h1, 64'd64, 64'h1, 1'b0, 2);
    run_op("sll4", 4'b0100, 64'h1, 64'd4, 64'h10, 1'b0, 5);
    run_op("srlhi", 4'b0101, 64'hFF00, 64'h100 | 64'd8,
           64'hFF, 1'b0, 9);

    // Mid-shift restart and operand change must be ignored.
    start  = 1'b1;
    alu_op = 4'b0101;
    in1    = 64'hF000_0000_0000_0000;
    in2    = 64'd8;
    tick();
    start = 1'b0;
    in1   = 64'h1;
    in2   = 64'd3;
    n = 1;
    repeat (3) begin
      tick();
      n++;
    end
    start  = 1'b1;
    alu_op = 4'b0010;
    tick();
    n++;
    start = 1'b0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check("ign lat", 64'(n), 64'd9);
    check("ign out", out, 64'h00F0_0000_0000_0000);
    tick();
    check("ign idle", 64'(busy), 64'd0);

    // Continuous start: one non-shift op every 3 cycles.
    start  = 1'b1;
    alu_op = 4'b0010;
    in1    = 64'd1;
    in2    = 64'd2;
    tick();
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b lat1", 64'(n), 64'd2);
    check("b2b out1", out, 64'd3);
    in2 = 64'd5;
    n = 0;
    tick();
    n++;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    start = 1'b0;
    check("b2b gap", 64'(n), 64'd3);
    check("b2b out2", out, 64'd6);
    tick();

    // Reset during SHIFT cycle 10 aborts without done.
    start  = 1'b1;
    alu_op = 4'b0101;
    in1    = ONES;
    in2    = 64'd40;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre rst busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ab busy", 64'(busy), 64'd0);
    check("ab done", 64'(done), 64'd0);
    check("ab out", out, 64'd0);
    check("ab zero", 64'(zero), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | done | busy;
    end
    check("ab quiet", 64'(seen), 64'd0);
    run_op("post", 4'b0010, 64'h20, 64'h22, 64'h42, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
